wide_add_sequencer: RTL and testbench
=====================================

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 4, width of the shared adder_nbit slice.
REQ-002 SHALL have parameter NUM_WORDS, default 4, slices per operand; legal range 2..16.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request new addition; sampled only in IDLE.
REQ-006 SHALL have port a  input  BIT_WIDTH*NUM_WORDS  operand A, latched on accepted start.
REQ-007 SHALL have port b  input  BIT_WIDTH*NUM_WORDS  operand B, latched on accepted start.
REQ-008 SHALL have port carry_in  input  1  initial carry, latched on accepted start.
REQ-009 SHALL have port busy  output  1  high in ADD and DONE states.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port sum  output  BIT_WIDTH*NUM_WORDS  registered result.
REQ-012 SHALL have port overflow  output  1  registered carry out of the most significant slice.

Function
REQ-013 SHALL perform all addition through exactly one adder_nbit instance of width BIT_WIDTH; no wider adder.
REQ-014 SHALL implement states IDLE, ADD, DONE; IDLE->ADD on start=1; ADD->DONE after word NUM_WORDS-1; DONE->IDLE unconditionally.
REQ-015 SHALL, on the edge accepting start, latch a, b, carry_in into operand/carry registers and clear the word index to 0.
REQ-016 SHALL, on each ADD edge, feed slice [idx] of A and B plus the carry register to the adder, write the slice sum into sum[idx], store the adder carry-out in the carry register, increment idx.
REQ-017 SHALL process slices least-significant first; idx wraps to 0 on entering DONE.
REQ-018 SHALL, on the final ADD edge, load overflow with that slice's carry-out.
REQ-019 SHALL assert done exactly in the cycle spent in DONE; start edge at k gives done high for the cycle after edge k+NUM_WORDS.
REQ-020 SHALL ignore start while busy=1; latched operands and progress unaffected.
REQ-021 SHALL hold sum and overflow stable from DONE until the next accepted start; sum slices may update during ADD.
REQ-022 SHALL accept start in the IDLE cycle immediately following DONE (back-to-back throughput NUM_WORDS+2 cycles).
REQ-023 SHALL treat input changes on a, b, carry_in after acceptance as don't-care.

Reset
REQ-024 SHALL, with rst=1 at any time including mid-ADD, immediately force state IDLE, busy=0, done=0, sum=0, overflow=0, carry register=0, idx=0.
REQ-025 SHALL abandon any in-progress operation on reset with no done pulse; first start after rst deasserts is accepted normally.

Configuration
REQ-026 SHALL, when macro WIDE_ADD_SUBTRACT_EN is defined, add port sub  input  1  latched with start; sub=1 latches bitwise-inverted b and forces the initial carry to 1 regardless of carry_in, yielding A-B; overflow then equals carry-out (1 = no borrow).
REQ-027 SHALL, when WIDE_ADD_SUBTRACT_EN is undefined, omit port sub and perform addition only.

Verification (BIT_WIDTH=4, NUM_WORDS=4)
REQ-028 SHALL cover: start with a=0x00FF, b=0x0001, carry_in=0 at edge k -> busy high from k, done high cycle after edge k+4, sum=0x0100, overflow=0.
REQ-029 SHALL cover: a=0xFFFF, b=0x0001 -> sum=0x0000, overflow=1.
REQ-030 SHALL cover: a=0x0000, b=0x0000, carry_in=1 -> sum=0x0001, overflow=0.
REQ-031 SHALL cover: start pulsed with new operands two cycles into ADD -> ignored, original result delivered; then back-to-back start in IDLE after DONE accepted.
REQ-032 SHALL cover: rst asserted after two ADD edges -> all outputs 0 asynchronously, no done; subsequent 0x1234+0x1111 yields 0x2345.
REQ-033 SHALL cover, with WIDE_ADD_SUBTRACT_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, overflow=0; a=0x0007, b=0x0005 -> sum=0x0002, overflow=1.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: NUM_WORDS slices of BIT_WIDTH bits summed LSB-first through one shared adder.
// Optional macro WIDE_ADD_SUBTRACT_EN adds a 'sub' port for A-B (overflow = no-borrow).

module adder_nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] s_o,
    output logic         c_o
);
    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, c_i};
endmodule

module wide_add_sequencer #(
    parameter int BIT_WIDTH = 4,
    parameter int NUM_WORDS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [BIT_WIDTH*NUM_WORDS-1:0] a,
    input  logic [BIT_WIDTH*NUM_WORDS-1:0] b,
    input  logic                           carry_in,
`ifdef WIDE_ADD_SUBTRACT_EN
    input  logic                           sub,
`endif
    output logic                           busy,
    output logic                           done,
    output logic [BIT_WIDTH*NUM_WORDS-1:0] sum,
    output logic                           overflow
);
    localparam int IW = $clog2(NUM_WORDS);
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    typedef logic [NUM_WORDS-1:0][BIT_WIDTH-1:0] word_vec_t;

    state_t         state_q, state_d;
    word_vec_t      a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic           carry_q, carry_d;
    logic           ovf_q, ovf_d;
    logic [IW-1:0]  idx_q, idx_d;

    logic [BIT_WIDTH-1:0] slice_s;
    logic                 slice_c;
    word_vec_t            b_in;
    logic                 cin_in;

    // The only adder in the design; every slice goes through it in turn.
    adder_nbit #(.N(BIT_WIDTH)) u_adder (
        .a_i (a_q[idx_q]),
        .b_i (b_q[idx_q]),
        .c_i (carry_q),
        .s_o (slice_s),
        .c_o (slice_c)
    );

    always_comb begin
        b_in   = b;
        cin_in = carry_in;
`ifdef WIDE_ADD_SUBTRACT_EN
        // A - B as A + ~B + 1
        if (sub) begin
            b_in   = ~b;
            cin_in = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADD;
                    a_d     = a;
                    b_d     = b_in;
                    carry_d = cin_in;
                    idx_d   = '0;
                end
            end
            ADD: begin
                sum_d[idx_q] = slice_s;
                carry_d      = slice_c;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    idx_d   = '0;
                    ovf_d   = slice_c;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer: stimulus pushes expected results, a monitor checks on done.
module tb_wide_add_sequencer;
    localparam int BW = 4;
    localparam int NW = 4;
    localparam int W  = BW * NW;

    logic         clk = 1'b0;
    logic         rst, start, carry_in;
    logic [W-1:0] a, b, sum;
    logic         busy, done, overflow;
    logic         sub;

    typedef struct {
        logic [W-1:0] s;
        logic         o;
        int unsigned  cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        last_exp;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wide_add_sequencer #(.BIT_WIDTH(BW), .NUM_WORDS(NW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
`ifdef WIDE_ADD_SUBTRACT_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .overflow (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands.
    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic ci, input logic sb, input int unsigned dcyc);
        exp_t       e;
        logic [W:0] full;
        if (sb) begin
            e.s = aa - bb;
            e.o = (aa >= bb);
        end else begin
            full = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ci};
            e.s  = full[W-1:0];
            e.o  = full[W];
        end
        e.cyc = dcyc;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("sum", sum, e.s);
                chk("overflow", overflow, e.o);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_in_done", busy, 1);
            end
        end
    end

    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci,
                         input logic sb, output int unsigned k);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 200);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got busy=1 expected idle within 200 cycles");
        end
        a = aa; b = bb; carry_in = ci; sub = sb; start = 1'b1;
        k = cyc + 1;
        last_exp = model(aa, bb, ci, sb, k + NW);
        q.push_back(last_exp);
        @(negedge clk);
        start = 1'b0;
        // inputs after acceptance are don't-care
        a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom); sub = 1'($urandom);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int unsigned k, k1;
        logic        sb;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum", sum, 0);
        chk("reset_overflow", overflow, 0);
        rst = 1'b0;

        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, k);
        drain();
        repeat (3) @(negedge clk);
        chk("sum_hold", sum, last_exp.s);
        chk("overflow_hold", overflow, last_exp.o);

        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, k);
        drain();
        issue(16'h0000, 16'h0000, 1'b1, 1'b0, k);
        drain();

        // start pulsed mid-ADD must be ignored, then a back-to-back start
        issue(16'h1357, 16'h2468, 1'b0, 1'b0, k1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        issue(16'hAAAA, 16'h5555, 1'b1, 1'b0, k);
        chk("b2b_accept_edge", k, k1 + NW + 2);
        drain();

        // reset after two ADD edges
        @(negedge clk);
        a = 16'h4321; b = 16'h8765; carry_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, k);
        drain();
        chk("post_rst_sum", sum, 16'h2345);

`ifdef WIDE_ADD_SUBTRACT_EN
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, k);
        issue(16'h0007, 16'h0005, 1'b1, 1'b1, k);
        drain();
`endif

        for (int i = 0; i < 24; i++) begin
`ifdef WIDE_ADD_SUBTRACT_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            issue(W'($urandom), W'($urandom), 1'($urandom), sb, k);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
